// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core's load/store path and the data-memory responder.
// The master (core side) issues requests and consumes responses; the slave is the responder.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_ready;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles, then
// accesses a word-organised RAM with byte lanes and returns a response.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus
);
    localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;

    // RAM is deliberately left out of reset; contents survive a reset pulse.
    logic [31:0] r_mem [0:DEPTH_WORDS-1];
    logic [31:0] r_ram_q;

    logic             w_err;
    logic             w_access;
    logic             w_we;
    logic             w_re;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_wlane;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;

    // Request legality is judged only on the latched copy, never on the live bus.
    always_comb begin
        w_err = 1'b0;
        if (r_size == 2'b11)                          w_err = 1'b1;
        if (r_size == 2'b01 && r_addr[0])             w_err = 1'b1;
        if (r_size == 2'b10 && r_addr[1:0] != 2'b00)  w_err = 1'b1;
        if ({2'b00, r_addr[31:2]} >= DEPTH_L)         w_err = 1'b1;
    end

    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_we     = w_access && r_write && !w_err;
    assign w_re     = w_access && !r_write && !w_err;
    assign w_idx    = r_addr[IDX_W+1:2];

    // Per-lane enable and replicated store data so each lane sees its own slice.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                w_be[gi]            = 1'b0;
                w_wlane[gi*8 +: 8]  = r_wdata[gi*8 +: 8];
                case (r_size)
                    2'b00: begin
                        w_be[gi]           = (r_addr[1:0] == 2'(gi));
                        w_wlane[gi*8 +: 8] = r_wdata[7:0];
                    end
                    2'b01: begin
                        w_be[gi]           = (r_addr[1] == 1'(gi / 2));
                        w_wlane[gi*8 +: 8] = r_wdata[(gi % 2)*8 +: 8];
                    end
                    2'b10:   w_be[gi] = 1'b1;
                    default: w_be[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    // Byte-lane RAM write and registered read, both happening on the access edge.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) r_mem[w_idx][k*8 +: 8] <= w_wlane[k*8 +: 8];
            end
        end
        if (w_re) r_ram_q <= r_mem[w_idx];
    end

    // Lane selection and sign/zero extension of the captured word.
    always_comb begin
        w_byte = r_ram_q[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_ram_q[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load = r_ram_q;
        endcase
    end

    // Request/wait/response sequencing with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write     <= bus.req_write;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_size      <= bus.req_size;
                        r_unsigned  <= bus.req_unsigned;
                        r_cnt       <= LAT;
                        r_req_ready <= 1'b0;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    // Load data is only presented for a successful load while the response is held.
    assign bus.resp_rdata = (r_resp_valid && !r_write && !r_resp_err) ? w_load : 32'd0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: a LATENCY=2 instance and a LATENCY=0 instance share
// one stimulus bus, selected by tb_sel, and are checked against a byte-array memory model.
module tb_data_mem_responder;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic        tb_sel       = 1'b0;
    logic        req_valid    = 1'b0;
    logic        req_write    = 1'b0;
    logic [31:0] req_addr     = 32'd0;
    logic [31:0] req_wdata    = 32'd0;
    logic [1:0]  req_size     = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        resp_ready   = 1'b1;

    data_mem_if if_a();
    data_mem_if if_b();

    assign if_a.req_valid    = req_valid & ~tb_sel;
    assign if_b.req_valid    = req_valid & tb_sel;
    assign if_a.req_write    = req_write;
    assign if_b.req_write    = req_write;
    assign if_a.req_addr     = req_addr;
    assign if_b.req_addr     = req_addr;
    assign if_a.req_wdata    = req_wdata;
    assign if_b.req_wdata    = req_wdata;
    assign if_a.req_size     = req_size;
    assign if_b.req_size     = req_size;
    assign if_a.req_unsigned = req_unsigned;
    assign if_b.req_unsigned = req_unsigned;
    assign if_a.resp_ready   = resp_ready;
    assign if_b.resp_ready   = resp_ready;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    logic        obs_ready, obs_valid, obs_err;
    logic [31:0] obs_rdata;
    assign obs_ready = tb_sel ? if_b.req_ready  : if_a.req_ready;
    assign obs_valid = tb_sel ? if_b.resp_valid : if_a.resp_valid;
    assign obs_err   = tb_sel ? if_b.resp_err   : if_a.resp_err;
    assign obs_rdata = tb_sel ? if_b.resp_rdata : if_a.resp_rdata;

    // Byte-addressed reference memory, one per instance.
    logic [7:0] ref_mem [0:1][0:4*DEPTH-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit sel, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [1:0] sz, input bit uns,
                                  output logic [31:0] rd, output bit er);
        int n;
        n  = 1 << sz;
        er = (sz == 2'd3) || ((addr % n) != 0) || ((addr / 4) >= DEPTH);
        rd = 32'd0;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < n; i++) ref_mem[sel][addr + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[sel][addr + i];
                if (n < 4 && !uns && rd[8*n-1])
                    for (int i = 8*n; i < 32; i++) rd[i] = 1'b1;
            end
        end
    endfunction

    task automatic xact(input bit sel, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input bit uns,
                        output logic [31:0] rd, output bit er, output int acc);
        logic [31:0] exp_rd;
        bit          exp_er;
        int          n;
        model(sel, wr, addr, wd, sz, uns, exp_rd, exp_er);
        @(negedge clk);
        tb_sel = sel; req_write = wr; req_addr = addr; req_wdata = wd;
        req_size = sz; req_unsigned = uns; req_valid = 1'b1;
        chk("req_ready_idle", obs_ready, 1'b1);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!obs_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, (sel ? 1 : 3));
        chk("resp_rdata", obs_rdata, exp_rd);
        chk("resp_err", obs_err, exp_er);
        rd = obs_rdata;
        er = obs_err;
        $display("txn dut=%0d wr=%0d addr=%08h wdata=%08h size=%0d uns=%0d -> rdata=%08h err=%0d lat=%0d",
                 sel, wr, addr, wd, sz, uns, obs_rdata, obs_err, n);
    endtask

    initial begin
        logic [31:0] rd, hold_rd, exp_rd, addr;
        bit          er, exp_er;
        int          acc, prev_acc, n;

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready_a", if_a.req_ready, 1'b1);
        chk("rst_valid_a", if_a.resp_valid, 1'b0);
        chk("rst_rdata_a", if_a.resp_rdata, 32'd0);
        chk("rst_err_a", if_a.resp_err, 1'b0);
        chk("rst_ready_b", if_b.req_ready, 1'b1);
        chk("rst_valid_b", if_b.resp_valid, 1'b0);

        // Give every word the tests touch a known value.
        for (int w = 0; w < 80; w++) xact(1'b0, 1'b1, w * 4, $urandom, 2'd2, 1'b0, rd, er, acc);

        // Word store then load.
        xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, rd, er, acc);
        chk("word_store_err", er, 1'b0);
        xact(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er, acc);
        chk("word_load", rd, 32'hDEADBEEF);

        // Byte lanes and extension.
        xact(1'b0, 1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, rd, er, acc);
        xact(1'b0, 1'b1, 32'h21, 32'h00000080, 2'd0, 1'b0, rd, er, acc);
        xact(1'b0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd, er, acc);
        chk("byte_merge", rd, 32'h11228044);
        xact(1'b0, 1'b0, 32'h21, 32'h0, 2'd0, 1'b0, rd, er, acc);
        chk("byte_signed", rd, 32'hFFFFFF80);
        xact(1'b0, 1'b0, 32'h21, 32'h0, 2'd0, 1'b1, rd, er, acc);
        chk("byte_unsigned", rd, 32'h00000080);
        xact(1'b0, 1'b0, 32'h22, 32'h0, 2'd1, 1'b0, rd, er, acc);
        chk("half_signed", rd, 32'h00001122);

        // Error cases leave memory untouched.
        xact(1'b0, 1'b0, 32'h03, 32'h0, 2'd1, 1'b0, rd, er, acc);
        chk("err_half_misalign", er, 1'b1);
        xact(1'b0, 1'b1, 32'h102, 32'h55555555, 2'd2, 1'b0, rd, er, acc);
        chk("err_word_misalign", er, 1'b1);
        xact(1'b0, 1'b0, 32'h400, 32'h0, 2'd2, 1'b0, rd, er, acc);
        chk("err_range", er, 1'b1);
        chk("err_range_rdata", rd, 32'd0);
        xact(1'b0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, rd, er, acc);

        // Backpressure: response held for 5 cycles, competing request ignored.
        model(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, exp_rd, exp_er);
        @(negedge clk);
        tb_sel = 1'b0; resp_ready = 1'b0;
        req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!obs_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rdata", obs_rdata, exp_rd);
        hold_rd = obs_rdata;
        req_write = 1'b1; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", obs_valid, 1'b1);
            chk("bp_rdata_stable", obs_rdata, hold_rd);
            chk("bp_ready_low", obs_ready, 1'b0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", obs_valid, 1'b0);
        chk("bp_release_ready", obs_ready, 1'b1);
        $display("txn dut=0 backpressure load addr=00000010 rdata=%08h held 5 cycles", hold_rd);
        xact(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er, acc);

        // Reset one cycle after accepting a store aborts it.
        @(negedge clk);
        tb_sel = 1'b0; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_ready", obs_ready, 1'b1);
        chk("rst_mid_valid", obs_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        $display("txn dut=0 store addr=00000040 wdata=cafef00d aborted by reset");
        xact(1'b0, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, rd, er, acc);

        // Randomised traffic on the LATENCY=2 instance.
        for (int t = 0; t < 150; t++) begin
            if (($urandom % 16) == 0) addr = 32'h400 + ($urandom % 64);
            else                      addr = $urandom % 32'h140;
            xact(1'b0, 1'($urandom % 2), addr, $urandom, 2'($urandom % 4), 1'($urandom % 2),
                 rd, er, acc);
        end

        // LATENCY=0 instance: one-cycle response, back-to-back every 3 cycles.
        for (int w = 0; w < 8; w++) xact(1'b1, 1'b1, w * 4, $urandom, 2'd2, 1'b0, rd, er, acc);
        prev_acc = acc;
        for (int t = 0; t < 12; t++) begin
            addr = $urandom % 32;
            xact(1'b1, 1'b0, addr, 32'h0, 2'($urandom % 3), 1'($urandom % 2), rd, er, acc);
            chk("b2b_spacing", acc - prev_acc, 3);
            prev_acc = acc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
